// File: rtl/kf8237_transfer_timing_control_if.sv
// rtl/kf8237_transfer_timing_control_if.sv - request, mode, handshake and bus-strobe bundle for the DMA sequencer
interface kf8237_transfer_timing_control_if;
  logic       master_clear;
  logic       controller_disable;
  logic [3:0] dma_request;
  logic [3:0] request_mask;
  logic [7:0] mode_transfer_type;
  logic [7:0] mode_transfer_mode;
  logic [3:0] mode_autoinitialize;
  logic       hold_acknowledge;
  logic       end_of_process_in;
  logic       underflow;
  logic       update_high_address;
  logic       hold_request;
  logic [3:0] dma_acknowledge;
  logic [3:0] transfer_register_select;
  logic       next_word;
  logic       initialize_current_register;
  logic       address_enable;
  logic       address_strobe;
  logic       io_read;
  logic       io_write;
  logic       memory_read;
  logic       memory_write;
  logic       end_of_process_out;
  logic [3:0] terminal_count;
  logic [3:0] set_mask;

  // Sequencer side: consumes requests/modes/flags, drives handshake and strobes
  modport master (
    input  master_clear, controller_disable, dma_request, request_mask,
    input  mode_transfer_type, mode_transfer_mode, mode_autoinitialize,
    input  hold_acknowledge, end_of_process_in, underflow, update_high_address,
    output hold_request, dma_acknowledge, transfer_register_select,
    output next_word, initialize_current_register, address_enable, address_strobe,
    output io_read, io_write, memory_read, memory_write,
    output end_of_process_out, terminal_count, set_mask
  );

  // System side: requesters, CPU and register file
  modport slave (
    output master_clear, controller_disable, dma_request, request_mask,
    output mode_transfer_type, mode_transfer_mode, mode_autoinitialize,
    output hold_acknowledge, end_of_process_in, underflow, update_high_address,
    input  hold_request, dma_acknowledge, transfer_register_select,
    input  next_word, initialize_current_register, address_enable, address_strobe,
    input  io_read, io_write, memory_read, memory_write,
    input  end_of_process_out, terminal_count, set_mask
  );
endinterface

// File: rtl/kf8237_transfer_timing_control.sv
// rtl/kf8237_transfer_timing_control.sv - KF8237 DMA arbitration, hold handshake and SI/S0/S1-S4 transfer sequencer
module kf8237_transfer_timing_control (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  kf8237_transfer_timing_control_if.master       io_bus
);

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_SC = 3'd2,
    ST_S1 = 3'd3,
    ST_S2 = 3'd4,
    ST_S3 = 3'd5,
    ST_S4 = 3'd6
  } state_t;

  localparam logic [1:0] TYPE_WRITE   = 2'b01;
  localparam logic [1:0] TYPE_READ    = 2'b10;
  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_select;
  logic [1:0] r_channel;
  logic       r_eop_latched;
  logic [3:0] r_terminal_count;

  logic       w_clear;
  logic [3:0] w_eligible;
  logic [3:0] w_grant;
  logic [1:0] w_grant_index;
  logic       w_arbitrate;
  logic [1:0] w_type;
  logic [1:0] w_mode;
  logic       w_autoinit;
  logic       w_dreq_selected;
  logic       w_service_end;

  logic       w_hold_request;
  logic [3:0] w_dma_acknowledge;
  logic       w_next_word;
  logic       w_initialize;
  logic       w_address_enable;
  logic       w_address_strobe;
  logic       w_io_read;
  logic       w_io_write;
  logic       w_memory_read;
  logic       w_memory_write;
  logic       w_eop_out;
  logic [3:0] w_set_mask;

  assign w_clear         = i_reset | io_bus.master_clear;
  assign w_eligible      = io_bus.dma_request & ~io_bus.request_mask;
  assign w_arbitrate     = ~io_bus.controller_disable & (|w_eligible);
  assign w_type          = io_bus.mode_transfer_type[{r_channel, 1'b0} +: 2];
  assign w_mode          = io_bus.mode_transfer_mode[{r_channel, 1'b0} +: 2];
  assign w_autoinit      = io_bus.mode_autoinitialize[r_channel];
  assign w_dreq_selected = |(io_bus.dma_request & r_select);
  assign w_service_end   = io_bus.underflow | r_eop_latched;

  // Fixed priority: scan from the top so the lowest-numbered eligible channel wins
  always_comb begin
    w_grant       = 4'b0000;
    w_grant_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_grant       = 4'b0001 << i;
        w_grant_index = 2'(i);
      end
    end
  end

  // State register; reset and master clear both land in SI on the same edge
  always_ff @(posedge i_clock) begin
    if (w_clear) r_state <= ST_SI;
    else         r_state <= w_next_state;
  end

  // Channel latch, EOP capture during the strobe states, sticky terminal count
  always_ff @(posedge i_clock) begin
    if (w_clear) begin
      r_select         <= 4'b0000;
      r_channel        <= 2'd0;
      r_eop_latched    <= 1'b0;
      r_terminal_count <= 4'b0000;
    end else begin
      if (r_state == ST_SI) begin
        r_eop_latched <= 1'b0;
        if (w_arbitrate) begin
          r_select  <= w_grant;
          r_channel <= w_grant_index;
        end
      end else if (w_next_state == ST_SI) begin
        r_select <= 4'b0000;
      end
      if (((r_state == ST_S2) || (r_state == ST_S3)) && io_bus.end_of_process_in)
        r_eop_latched <= 1'b1;
      if ((r_state == ST_S4) && io_bus.underflow)
        r_terminal_count <= r_terminal_count | r_select;
    end
  end

  // Next-state and per-state output decode
  always_comb begin
    w_next_state      = r_state;
    w_hold_request    = 1'b0;
    w_dma_acknowledge = 4'b0000;
    w_next_word       = 1'b0;
    w_initialize      = 1'b0;
    w_address_enable  = 1'b0;
    w_address_strobe  = 1'b0;
    w_io_read         = 1'b0;
    w_io_write        = 1'b0;
    w_memory_read     = 1'b0;
    w_memory_write    = 1'b0;
    w_eop_out         = 1'b0;
    w_set_mask        = 4'b0000;
    case (r_state)
      ST_SI: begin
        if (w_arbitrate) w_next_state = ST_S0;
      end
      ST_S0: begin
        w_hold_request = 1'b1;
        if (io_bus.hold_acknowledge)
          w_next_state = (w_mode == MODE_CASCADE) ? ST_SC : ST_S1;
        else if (!w_dreq_selected && (w_mode != MODE_BLOCK))
          w_next_state = ST_SI;
      end
      ST_SC: begin
        w_hold_request    = 1'b1;
        w_dma_acknowledge = r_select;
        if (!w_dreq_selected) w_next_state = ST_SI;
      end
      ST_S1: begin
        w_hold_request    = 1'b1;
        w_dma_acknowledge = r_select;
        w_address_enable  = 1'b1;
        w_address_strobe  = 1'b1;
        w_next_state      = ST_S2;
      end
      ST_S2, ST_S3: begin
        w_hold_request    = 1'b1;
        w_dma_acknowledge = r_select;
        w_address_enable  = 1'b1;
        w_memory_read     = (w_type == TYPE_READ);
        w_io_read         = (w_type == TYPE_WRITE);
        if (r_state == ST_S3) begin
          w_io_write     = (w_type == TYPE_READ);
          w_memory_write = (w_type == TYPE_WRITE);
          w_next_state   = ST_S4;
        end else begin
          w_next_state   = ST_S3;
        end
      end
      ST_S4: begin
        w_hold_request    = 1'b1;
        w_dma_acknowledge = r_select;
        w_address_enable  = 1'b1;
        w_eop_out         = w_service_end;
        w_next_word       = ~w_service_end;
        w_initialize      = w_service_end & w_autoinit;
        w_set_mask        = (w_service_end & ~w_autoinit) ? r_select : 4'b0000;
        if (w_service_end)
          w_next_state = ST_SI;
        else if ((w_mode == MODE_BLOCK) || ((w_mode == MODE_DEMAND) && w_dreq_selected))
          w_next_state = io_bus.update_high_address ? ST_S1 : ST_S2;
        else
          w_next_state = ST_SI;
      end
      default: w_next_state = ST_SI;
    endcase
  end

  assign io_bus.hold_request                = w_hold_request;
  assign io_bus.dma_acknowledge             = w_dma_acknowledge;
  assign io_bus.transfer_register_select    = r_select;
  assign io_bus.next_word                   = w_next_word;
  assign io_bus.initialize_current_register = w_initialize;
  assign io_bus.address_enable              = w_address_enable;
  assign io_bus.address_strobe              = w_address_strobe;
  assign io_bus.io_read                     = w_io_read;
  assign io_bus.io_write                    = w_io_write;
  assign io_bus.memory_read                 = w_memory_read;
  assign io_bus.memory_write                = w_memory_write;
  assign io_bus.end_of_process_out          = w_eop_out;
  assign io_bus.terminal_count              = r_terminal_count;
  assign io_bus.set_mask                    = w_set_mask;

endmodule

// File: tb/tb_kf8237_transfer_timing_control.sv
// tb/tb_kf8237_transfer_timing_control.sv - directed self-checking bench for the DMA transfer sequencer
module tb_kf8237_transfer_timing_control;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  kf8237_transfer_timing_control_if bus ();

  kf8237_transfer_timing_control dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst                      = 1'b1;
    bus.master_clear         = 1'b0;
    bus.controller_disable   = 1'b0;
    bus.dma_request          = 4'b0000;
    bus.request_mask         = 4'b0000;
    bus.mode_transfer_type   = 8'h00;
    bus.mode_transfer_mode   = 8'h00;
    bus.mode_autoinitialize  = 4'b0000;
    bus.hold_acknowledge     = 1'b0;
    bus.end_of_process_in    = 1'b0;
    bus.underflow            = 1'b0;
    bus.update_high_address  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    do_reset();
    outs = {bus.hold_request, bus.dma_acknowledge, bus.transfer_register_select, bus.next_word,
            bus.initialize_current_register, bus.address_enable, bus.address_strobe, bus.io_read,
            bus.io_write, bus.memory_read, bus.memory_write, bus.end_of_process_out,
            bus.terminal_count, bus.set_mask, 5'b0};
    checks++; if (outs !== 32'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", outs, 32'h0); end
    // master clear mid-transfer (S2) drops everything at the next edge
    bus.mode_transfer_type = 8'b0000_0010;
    bus.mode_transfer_mode = 8'b0000_0001;
    bus.hold_acknowledge   = 1'b1;
    bus.dma_request        = 4'b0001;
    tick(); tick(); tick();
    checks++; if (bus.memory_read !== 1'b1) begin errors++; $display("FAIL mc_pre_memr got=%b exp=1", bus.memory_read); end
    bus.master_clear = 1'b1;
    bus.dma_request  = 4'b0000;
    tick();
    bus.master_clear = 1'b0;
    checks++; if ({bus.hold_request, bus.memory_read, bus.address_enable, bus.dma_acknowledge} !== 7'b0)
      begin errors++; $display("FAIL mc_outputs got=%b exp=0000000", {bus.hold_request, bus.memory_read, bus.address_enable, bus.dma_acknowledge}); end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.mode_transfer_type = 8'b0010_0000;
    bus.mode_transfer_mode = 8'b0001_0000;
    bus.dma_request        = 4'b0100;
    #1;
    checks++; if (bus.hold_request !== 1'b0) begin errors++; $display("FAIL single_si_hrq got=%b exp=0", bus.hold_request); end
    tick(); // S0
    checks++; if (bus.hold_request !== 1'b1) begin errors++; $display("FAIL single_s0_hrq got=%b exp=1", bus.hold_request); end
    checks++; if (bus.transfer_register_select !== 4'b0100) begin errors++; $display("FAIL single_s0_sel got=%b exp=0100", bus.transfer_register_select); end
    checks++; if (bus.dma_acknowledge !== 4'b0000) begin errors++; $display("FAIL single_s0_dack got=%b exp=0000", bus.dma_acknowledge); end
    bus.hold_acknowledge = 1'b1;
    tick(); // S1
    checks++; if ({bus.address_enable, bus.address_strobe, bus.memory_read} !== 3'b110) begin errors++; $display("FAIL single_s1 aen/adstb/memr got=%b exp=110", {bus.address_enable, bus.address_strobe, bus.memory_read}); end
    checks++; if (bus.dma_acknowledge !== 4'b0100) begin errors++; $display("FAIL single_s1_dack got=%b exp=0100", bus.dma_acknowledge); end
    tick(); // S2
    checks++; if ({bus.address_strobe, bus.memory_read, bus.io_write} !== 3'b010) begin errors++; $display("FAIL single_s2 adstb/memr/iow got=%b exp=010", {bus.address_strobe, bus.memory_read, bus.io_write}); end
    bus.dma_request = 4'b0000;
    tick(); // S3
    checks++; if ({bus.memory_read, bus.io_write, bus.io_read, bus.memory_write} !== 4'b1100) begin errors++; $display("FAIL single_s3 memr/iow/ior/memw got=%b exp=1100", {bus.memory_read, bus.io_write, bus.io_read, bus.memory_write}); end
    tick(); // S4
    checks++; if ({bus.memory_read, bus.io_write, bus.next_word, bus.end_of_process_out} !== 4'b0010) begin errors++; $display("FAIL single_s4 memr/iow/nw/eop got=%b exp=0010", {bus.memory_read, bus.io_write, bus.next_word, bus.end_of_process_out}); end
    tick(); // SI
    checks++; if ({bus.hold_request, bus.dma_acknowledge, bus.transfer_register_select, bus.next_word} !== 10'b0) begin errors++; $display("FAIL single_exit got=%b exp=0", {bus.hold_request, bus.dma_acknowledge, bus.transfer_register_select, bus.next_word}); end
  endtask

  task automatic test_block_underflow(input logic autoinit);
    int         nw, icr, adstb, eop, sm, s4;
    logic [3:0] sm_val;
    bit         done;
    nw = 0; icr = 0; adstb = 0; eop = 0; sm = 0; s4 = 0; sm_val = 4'b0000; done = 1'b0;
    do_reset();
    bus.mode_transfer_type  = 8'b0000_0001;
    bus.mode_transfer_mode  = 8'b0000_0010;
    bus.mode_autoinitialize = {3'b000, autoinit};
    bus.hold_acknowledge    = 1'b1;
    bus.dma_request         = 4'b0001;
    tick(); // S0
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      tick();
      bus.underflow = 1'b0;
      if (bus.address_enable && !bus.address_strobe && !bus.io_read && !bus.memory_write) begin
        s4++;
        if (s4 == 3) begin
          bus.underflow   = 1'b1;
          bus.dma_request = 4'b0000;
        end
      end
      #1;
      nw    += int'(bus.next_word);
      icr   += int'(bus.initialize_current_register);
      adstb += int'(bus.address_strobe);
      eop   += int'(bus.end_of_process_out);
      if (bus.set_mask != 4'b0000) begin sm++; sm_val = bus.set_mask; end
      if (!bus.hold_request) done = 1'b1;
    end
    bus.underflow = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL block_timeout got=%b exp=1", done); end
    checks++; if (s4 !== 3) begin errors++; $display("FAIL block_s4_count got=%0d exp=3", s4); end
    checks++; if (nw !== 2) begin errors++; $display("FAIL block_next_word got=%0d exp=2", nw); end
    checks++; if (adstb !== 1) begin errors++; $display("FAIL block_adstb got=%0d exp=1", adstb); end
    checks++; if (eop !== 1) begin errors++; $display("FAIL block_eop got=%0d exp=1", eop); end
    checks++; if (bus.terminal_count !== 4'b0001) begin errors++; $display("FAIL block_tc got=%b exp=0001", bus.terminal_count); end
    checks++; if (icr !== (autoinit ? 1 : 0)) begin errors++; $display("FAIL block_init got=%0d exp=%0d", icr, autoinit ? 1 : 0); end
    checks++; if (sm !== (autoinit ? 0 : 1)) begin errors++; $display("FAIL block_set_mask_count got=%0d exp=%0d", sm, autoinit ? 0 : 1); end
    if (!autoinit) begin
      checks++; if (sm_val !== 4'b0001) begin errors++; $display("FAIL block_set_mask_val got=%b exp=0001", sm_val); end
    end
    checks++; if (bus.dma_acknowledge !== 4'b0000) begin errors++; $display("FAIL block_exit_dack got=%b exp=0000", bus.dma_acknowledge); end
  endtask

  task automatic test_priority_mask();
    do_reset();
    bus.mode_transfer_mode = 8'b0101_0101;
    bus.hold_acknowledge   = 1'b1;
    bus.request_mask       = 4'b0010;
    bus.dma_request        = 4'b1010;
    tick(); // S0
    checks++; if (bus.transfer_register_select !== 4'b1000) begin errors++; $display("FAIL prio_masked_sel got=%b exp=1000", bus.transfer_register_select); end
    bus.dma_request = 4'b0000;
    tick(); // S1
    checks++; if (bus.dma_acknowledge !== 4'b1000) begin errors++; $display("FAIL prio_masked_dack got=%b exp=1000", bus.dma_acknowledge); end
    tick(); tick(); tick(); tick(); // S2 S3 S4 SI
    bus.request_mask = 4'b0000;
    bus.dma_request  = 4'b0110;
    tick(); // S0
    checks++; if (bus.transfer_register_select !== 4'b0010) begin errors++; $display("FAIL prio_low_wins got=%b exp=0010", bus.transfer_register_select); end
    do_reset();
    bus.controller_disable = 1'b1;
    bus.dma_request        = 4'b0001;
    tick(); tick();
    checks++; if ({bus.hold_request, bus.transfer_register_select} !== 5'b0) begin errors++; $display("FAIL prio_disabled got=%b exp=00000", {bus.hold_request, bus.transfer_register_select}); end
  endtask

  task automatic test_demand_drop();
    do_reset();
    bus.mode_transfer_type = 8'b0000_0010;
    bus.mode_transfer_mode = 8'b0000_0000;
    bus.hold_acknowledge   = 1'b1;
    bus.dma_request        = 4'b0001;
    tick(); tick(); tick(); tick(); tick(); // S0 S1 S2 S3 S4
    checks++; if (bus.next_word !== 1'b1) begin errors++; $display("FAIL demand_s4a_nw got=%b exp=1", bus.next_word); end
    tick(); // S2 of 2nd transfer, no ADSTB
    checks++; if ({bus.address_enable, bus.address_strobe, bus.memory_read} !== 3'b101) begin errors++; $display("FAIL demand_b2b_s2 got=%b exp=101", {bus.address_enable, bus.address_strobe, bus.memory_read}); end
    bus.dma_request = 4'b0000;
    tick(); // S3
    checks++; if (bus.io_write !== 1'b1) begin errors++; $display("FAIL demand_s3b_iow got=%b exp=1", bus.io_write); end
    tick(); // S4
    checks++; if (bus.next_word !== 1'b1) begin errors++; $display("FAIL demand_s4b_nw got=%b exp=1", bus.next_word); end
    tick(); // SI
    checks++; if ({bus.hold_request, bus.dma_acknowledge} !== 5'b0) begin errors++; $display("FAIL demand_exit got=%b exp=00000", {bus.hold_request, bus.dma_acknowledge}); end
  endtask

  task automatic test_eop_in();
    do_reset();
    bus.mode_transfer_type = 8'b0000_0010;
    bus.mode_transfer_mode = 8'b0000_0001;
    bus.hold_acknowledge   = 1'b1;
    bus.dma_request        = 4'b0001;
    tick(); tick(); tick(); // S0 S1 S2
    bus.dma_request = 4'b0000;
    tick(); // S3
    bus.end_of_process_in = 1'b1;
    tick(); // S4
    bus.end_of_process_in = 1'b0;
    #1;
    checks++; if ({bus.end_of_process_out, bus.next_word} !== 2'b10) begin errors++; $display("FAIL eop_s4 eop/nw got=%b exp=10", {bus.end_of_process_out, bus.next_word}); end
    checks++; if (bus.set_mask !== 4'b0001) begin errors++; $display("FAIL eop_set_mask got=%b exp=0001", bus.set_mask); end
    tick(); // SI
    checks++; if ({bus.terminal_count, bus.hold_request} !== 5'b0) begin errors++; $display("FAIL eop_tc_hrq got=%b exp=00000", {bus.terminal_count, bus.hold_request}); end
  endtask

  task automatic test_reset_mid_and_cascade();
    do_reset();
    bus.mode_transfer_type = 8'b0010_0000;
    bus.mode_transfer_mode = 8'b0001_0000;
    bus.hold_acknowledge   = 1'b1;
    bus.dma_request        = 4'b0100;
    tick(); tick(); tick(); tick(); // S0 S1 S2 S3
    checks++; if (bus.io_write !== 1'b1) begin errors++; $display("FAIL rst_pre_iow got=%b exp=1", bus.io_write); end
    rst             = 1'b1;
    bus.dma_request = 4'b0000;
    tick();
    rst = 1'b0;
    checks++; if ({bus.hold_request, bus.dma_acknowledge, bus.transfer_register_select, bus.memory_read, bus.io_write, bus.address_enable, bus.next_word} !== 13'b0)
      begin errors++; $display("FAIL rst_mid_outputs got=%b exp=0", {bus.hold_request, bus.dma_acknowledge, bus.transfer_register_select, bus.memory_read, bus.io_write, bus.address_enable, bus.next_word}); end
    tick();
    checks++; if (bus.hold_request !== 1'b0) begin errors++; $display("FAIL rst_stays_si got=%b exp=0", bus.hold_request); end
    bus.mode_transfer_mode = 8'b0000_1100;
    bus.mode_transfer_type = 8'b0000_1000;
    bus.dma_request        = 4'b0010;
    tick(); tick(); // S0 SC
    for (int k = 0; k < 3; k++) begin
      checks++; if ({bus.dma_acknowledge, bus.address_enable, bus.memory_read, bus.io_write, bus.io_read, bus.memory_write, bus.hold_request} !== 10'b0010_000001)
        begin errors++; $display("FAIL cascade_hold%0d got=%b exp=0010000001", k, {bus.dma_acknowledge, bus.address_enable, bus.memory_read, bus.io_write, bus.io_read, bus.memory_write, bus.hold_request}); end
      tick();
    end
    bus.dma_request = 4'b0000;
    tick();
    checks++; if ({bus.dma_acknowledge, bus.hold_request} !== 5'b0) begin errors++; $display("FAIL cascade_exit got=%b exp=00000", {bus.dma_acknowledge, bus.hold_request}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_single_read();
    test_block_underflow(1'b0);
    test_block_underflow(1'b1);
    test_priority_mask();
    test_demand_drop();
    test_eop_in();
    test_reset_mid_and_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
